// File: rtl/bw_frame_sched.sv
// bw_frame_sched: walks a frame buffer and converts each RGB444 pixel in place
// to grayscale (nibble sum / 4, replicated to {g,g,g}). The single memory port
// is shared with the display fetch, which always wins arbitration.
// Optional feature: define BW_SCHED_THRESHOLD_EN to write a binary image
// (g >= THRESH -> 12'hFFF, else 12'h000) instead of {g,g,g}.
module bw_frame_sched #(
    parameter int ADDR_W       = 17,
    parameter int FRAME_PIXELS = 76800,
    parameter int THRESH       = 8
) (
    input  logic              gclk,
    input  logic              grst_n,
    input  logic              start,
    output logic              busy,
    output logic              done,
    input  logic              disp_req,
    input  logic [ADDR_W-1:0] disp_addr,
    output logic              disp_gnt,
    output logic              disp_valid,
    output logic [ADDR_W-1:0] mem_addr,
    output logic              mem_we,
    output logic [11:0]       mem_wdata,
    input  logic [11:0]       mem_rdata
);

    typedef enum logic [2:0] {S_IDLE, S_RD, S_WT, S_WR, S_DONE} state_t;

    localparam logic [ADDR_W-1:0] LAST = ADDR_W'(FRAME_PIXELS - 1);

    state_t            state;
    logic [ADDR_W-1:0] cnt;
    logic [11:0]       pix;
    logic [5:0]        sum;
    logic [3:0]        g;

    // Luma: nibble sum (max 45) fits in 6 bits; divide by 4 by dropping two LSBs
    assign sum = {2'b00, pix[11:8]} + {2'b00, pix[7:4]} + {2'b00, pix[3:0]};
    assign g   = 4'(sum >> 2);

`ifdef BW_SCHED_THRESHOLD_EN
    localparam logic [3:0] THRESH_G = 4'(THRESH);
    assign mem_wdata = (g >= THRESH_G) ? 12'hFFF : 12'h000;
`else
    assign mem_wdata = {g, g, g};
`endif

    // Display owns the port whenever it asks; converter write is also
    // blocked while reset is asserted so a mid-frame reset never lands a write.
    assign disp_gnt = disp_req;
    assign mem_addr = disp_req ? disp_addr : cnt;
    assign mem_we   = grst_n && !disp_req && (state == S_WR);

    // Conversion sequencer: RD issues the read, WT captures data, WR writes back
    always_ff @(posedge gclk) begin
        if (!grst_n) begin
            state <= S_IDLE;
            cnt   <= '0;
            pix   <= '0;
            busy  <= 1'b0;
            done  <= 1'b0;
        end else begin
            case (state)
                S_IDLE: begin
                    if (start) begin
                        cnt   <= '0;
                        busy  <= 1'b1;
                        state <= S_RD;
                    end
                end
                S_RD: begin
                    if (!disp_req) state <= S_WT;
                end
                S_WT: begin
                    // rdata holds the read issued in RD, even if display was granted now
                    pix   <= mem_rdata;
                    state <= S_WR;
                end
                S_WR: begin
                    if (!disp_req) begin
                        if (cnt == LAST) begin
                            done  <= 1'b1;
                            state <= S_DONE;
                        end else begin
                            cnt   <= cnt + 1'b1;
                            state <= S_RD;
                        end
                    end
                end
                S_DONE: begin
                    done  <= 1'b0;
                    busy  <= 1'b0;
                    state <= S_IDLE;
                end
                default: state <= S_IDLE;
            endcase
        end
    end

    // Display data qualifier: grant delayed to line up with synchronous read data
    always_ff @(posedge gclk) begin
        if (!grst_n) disp_valid <= 1'b0;
        else         disp_valid <= disp_gnt;
    end

endmodule

// File: tb/tb_bw_frame_sched.sv
// Bench for bw_frame_sched with a 4-pixel frame and a behavioural sync RAM.
// A write scoreboard holds expected (addr, data) per converter write, and a
// display queue holds the RAM word each granted display read should return.
module tb_bw_frame_sched;

    localparam int AW = 8;
    localparam int FP = 4;

    logic          gclk, grst_n, start, busy, done;
    logic          disp_req, disp_gnt, disp_valid, mem_we;
    logic [AW-1:0] disp_addr, mem_addr;
    logic [11:0]   mem_wdata, mem_rdata;

    typedef struct packed {
        logic [AW-1:0] addr;
        logic [11:0]   data;
    } wr_t;

    logic [11:0] ram [0:255];
    logic [11:0] fin [0:FP-1];
    wr_t         wq[$];
    logic [11:0] dq[$];
    int          errors = 0;
    int          checks = 0;

    bw_frame_sched #(.ADDR_W(AW), .FRAME_PIXELS(FP), .THRESH(8)) dut (
        .gclk(gclk), .grst_n(grst_n), .start(start), .busy(busy), .done(done),
        .disp_req(disp_req), .disp_addr(disp_addr), .disp_gnt(disp_gnt),
        .disp_valid(disp_valid), .mem_addr(mem_addr), .mem_we(mem_we),
        .mem_wdata(mem_wdata), .mem_rdata(mem_rdata)
    );

    initial begin
        gclk = 1'b0;
        forever #5 gclk = ~gclk;
    end

    // Synchronous single-port RAM
    always @(posedge gclk) begin
        if (mem_we) ram[mem_addr] <= mem_wdata;
        mem_rdata <= ram[mem_addr];
    end

    function automatic logic [11:0] exp_gray(input logic [11:0] p);
        int s;
        logic [3:0] gv;
        s  = int'(p[11:8]) + int'(p[7:4]) + int'(p[3:0]);
        gv = 4'(s / 4);
`ifdef BW_SCHED_THRESHOLD_EN
        return (gv >= 4'd8) ? 12'hFFF : 12'h000;
`else
        return {gv, gv, gv};
`endif
    endfunction

    // Monitor: pop/compare display data and converter writes as they appear
    always @(negedge gclk) begin
        logic [11:0] e;
        wr_t w;
        if (disp_valid) begin
            checks++;
            if (dq.size() == 0) begin
                errors++;
                $display("FAIL disp_valid_unexpected: got valid with data %h, want no valid", mem_rdata);
            end else begin
                e = dq.pop_front();
                if (mem_rdata !== e) begin
                    errors++;
                    $display("FAIL disp_data: got %h want %h", mem_rdata, e);
                end
            end
        end
        if (disp_req && grst_n) begin
            checks++;
            if (disp_gnt !== 1'b1 || mem_addr !== disp_addr || mem_we !== 1'b0) begin
                errors++;
                $display("FAIL disp_port: gnt=%b addr=%h we=%b want 1 %h 0", disp_gnt, mem_addr, mem_we, disp_addr);
            end
            dq.push_back(ram[disp_addr]);
        end
        if (mem_we) begin
            checks++;
            if (wq.size() == 0) begin
                errors++;
                $display("FAIL write_unexpected: got addr %h data %h, want none", mem_addr, mem_wdata);
            end else begin
                w = wq.pop_front();
                if (mem_addr !== w.addr || mem_wdata !== w.data) begin
                    errors++;
                    $display("FAIL write: got %h<=%h want %h<=%h", mem_addr, mem_wdata, w.addr, w.data);
                end
            end
        end
    end

    task automatic load_ram(input logic [11:0] a, input logic [11:0] b,
                            input logic [11:0] c, input logic [11:0] d);
        ram[0] = a; ram[1] = b; ram[2] = c; ram[3] = d;
    endtask

    task automatic push_frame(input int n);
        for (int i = 0; i < FP; i++) fin[i] = exp_gray(ram[i]);
        for (int i = 0; i < n; i++) wq.push_back('{addr: AW'(i), data: fin[i]});
    endtask

    task automatic test_reset();
        grst_n = 1'b0; start = 1'b0; disp_req = 1'b0; disp_addr = '0;
        repeat (2) @(posedge gclk);
        #1;
        @(negedge gclk);
        checks++;
        if (busy !== 1'b0 || done !== 1'b0 || disp_valid !== 1'b0) begin
            errors++;
            $display("FAIL reset_regs: got busy=%b done=%b valid=%b want 0 0 0", busy, done, disp_valid);
        end
        checks++;
        if (mem_we !== 1'b0 || mem_addr !== '0 || disp_gnt !== 1'b0) begin
            errors++;
            $display("FAIL reset_port: got we=%b addr=%h gnt=%b want 0 00 0", mem_we, mem_addr, disp_gnt);
        end
        @(posedge gclk); #1;
        disp_req = 1'b1; disp_addr = 8'h03;
        @(negedge gclk);
        checks++;
        if (mem_addr !== 8'h03 || disp_gnt !== 1'b1 || mem_we !== 1'b0) begin
            errors++;
            $display("FAIL reset_disp_port: got addr=%h gnt=%b we=%b want 03 1 0", mem_addr, disp_gnt, mem_we);
        end
        @(posedge gclk); #1;
        @(negedge gclk);
        checks++;
        if (disp_valid !== 1'b0) begin
            errors++;
            $display("FAIL reset_disp_valid: got %b want 0", disp_valid);
        end
        @(posedge gclk); #1;
        disp_req = 1'b0; disp_addr = '0; grst_n = 1'b1;
        @(posedge gclk); #1;
    endtask

    task automatic test_uncontended();
        load_ram(12'hF00, 12'hFFF, 12'h123, 12'h000);
        push_frame(FP);
        checks++;
        if (fin[0] !== exp_gray(12'hF00) || ram[1] !== 12'hFFF) begin
            errors++;
            $display("FAIL uncont_setup: got %h want %h", fin[0], exp_gray(12'hF00));
        end
        start = 1'b1; @(posedge gclk); #1; start = 1'b0;
        for (int k = 1; k <= 15; k++) begin
            @(negedge gclk);
            checks++;
            if (done !== (k == 13) || busy !== (k <= 13)) begin
                errors++;
                $display("FAIL uncont_c%0d: got done=%b busy=%b want %b %b", k, done, busy, k == 13, k <= 13);
            end
            @(posedge gclk); #1;
        end
`ifndef BW_SCHED_THRESHOLD_EN
        checks++;
        if (ram[0] !== 12'h333 || ram[1] !== 12'hBBB || ram[2] !== 12'h111 || ram[3] !== 12'h000) begin
            errors++;
            $display("FAIL uncont_ram: got %h %h %h %h want 333 BBB 111 000", ram[0], ram[1], ram[2], ram[3]);
        end
`endif
        checks++;
        if (wq.size() != 0) begin
            errors++;
            $display("FAIL uncont_writes_left: got %0d want 0", wq.size());
        end
    endtask

    task automatic test_contention();
        load_ram(12'hF00, 12'hFFF, 12'h123, 12'h000);
        push_frame(FP);
        start = 1'b1; @(posedge gclk); #1; start = 1'b0;
        for (int k = 1; k <= 23; k++) begin
            disp_req  = (k % 5 == 1) || (k % 5 == 2);
            disp_addr = AW'(k % 4);
            @(negedge gclk);
            checks++;
            if (done !== (k == 21) || busy !== (k <= 21)) begin
                errors++;
                $display("FAIL contend_c%0d: got done=%b busy=%b want %b %b", k, done, busy, k == 21, k <= 21);
            end
            @(posedge gclk); #1;
        end
        disp_req = 1'b0;
        @(posedge gclk); #1;
        for (int i = 0; i < FP; i++) begin
            checks++;
            if (ram[i] !== fin[i]) begin
                errors++;
                $display("FAIL contend_ram%0d: got %h want %h", i, ram[i], fin[i]);
            end
        end
        checks++;
        if (wq.size() != 0 || dq.size() != 0) begin
            errors++;
            $display("FAIL contend_queues: got wq=%0d dq=%0d want 0 0", wq.size(), dq.size());
        end
    endtask

    task automatic test_wt_grant();
        load_ram(12'hFFF, 12'h888, 12'hF00, 12'h0F0);
        push_frame(FP);
        start = 1'b1; @(posedge gclk); #1; start = 1'b0;
        for (int k = 1; k <= 14; k++) begin
            disp_req  = (k % 3 == 2) && (k <= 12);
            disp_addr = AW'(3 - (k / 3) % 4);
            @(negedge gclk);
            checks++;
            if (done !== (k == 13) || busy !== (k <= 13)) begin
                errors++;
                $display("FAIL wt_c%0d: got done=%b busy=%b want %b %b", k, done, busy, k == 13, k <= 13);
            end
            @(posedge gclk); #1;
        end
        disp_req = 1'b0;
        @(posedge gclk); #1;
        checks++;
        if (wq.size() != 0 || ram[1] !== fin[1] || ram[3] !== fin[3]) begin
            errors++;
            $display("FAIL wt_result: got wq=%0d ram1=%h want 0 %h", wq.size(), ram[1], fin[1]);
        end
    endtask

    task automatic test_reset_midframe();
        load_ram(12'hF00, 12'hFFF, 12'h123, 12'h000);
        push_frame(2);
        start = 1'b1; @(posedge gclk); #1; start = 1'b0;
        for (int k = 1; k <= 9; k++) begin
            if (k == 9) grst_n = 1'b0;
            @(negedge gclk);
            if (k == 9) begin
                checks++;
                if (mem_we !== 1'b0) begin
                    errors++;
                    $display("FAIL midrst_we: got %b want 0", mem_we);
                end
            end
            @(posedge gclk); #1;
        end
        @(negedge gclk);
        checks++;
        if (busy !== 1'b0 || done !== 1'b0 || disp_valid !== 1'b0 || mem_addr !== '0 || mem_we !== 1'b0) begin
            errors++;
            $display("FAIL midrst_regs: got busy=%b done=%b valid=%b addr=%h we=%b want 0 0 0 00 0",
                     busy, done, disp_valid, mem_addr, mem_we);
        end
        @(posedge gclk); #1;
        grst_n = 1'b1;
        @(posedge gclk); #1;
        checks++;
        if (wq.size() != 0 || ram[2] !== 12'h123 || ram[0] !== fin[0] || ram[1] !== fin[1]) begin
            errors++;
            $display("FAIL midrst_ram: got wq=%0d ram=%h %h %h want 0 %h %h 123",
                     wq.size(), ram[0], ram[1], ram[2], fin[0], fin[1]);
        end
        push_frame(FP);
        start = 1'b1; @(posedge gclk); #1; start = 1'b0;
        for (int k = 1; k <= 14; k++) begin
            @(negedge gclk);
            checks++;
            if (done !== (k == 13)) begin
                errors++;
                $display("FAIL midrst_redo_c%0d: got done=%b want %b", k, done, k == 13);
            end
            @(posedge gclk); #1;
        end
        checks++;
        if (wq.size() != 0) begin
            errors++;
            $display("FAIL midrst_redo_left: got %0d want 0", wq.size());
        end
    endtask

    task automatic test_start_busy();
        int ndone;
        ndone = 0;
        load_ram(12'h5A3, 12'h0F0, 12'h00F, 12'hEEE);
        push_frame(FP);
        start = 1'b1; @(posedge gclk); #1; start = 1'b0;
        for (int k = 1; k <= 18; k++) begin
            start = (k == 5);
            @(negedge gclk);
            if (done === 1'b1) ndone++;
            checks++;
            if (done !== (k == 13) || busy !== (k <= 13)) begin
                errors++;
                $display("FAIL sbusy_c%0d: got done=%b busy=%b want %b %b", k, done, busy, k == 13, k <= 13);
            end
            @(posedge gclk); #1;
        end
        start = 1'b0;
        checks++;
        if (ndone != 1 || wq.size() != 0) begin
            errors++;
            $display("FAIL sbusy_single_done: got dones=%0d wq=%0d want 1 0", ndone, wq.size());
        end
    endtask

    initial begin
        test_reset();
        test_uncontended();
        test_contention();
        test_wt_grant();
        test_reset_midframe();
        test_start_busy();
        repeat (2) @(posedge gclk);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
